// File: rtl/seg7_scan_mux_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux_if
//   Bundles the pattern inputs and display outputs of seg7_scan_mux.
//   master : pattern source / display observer (drives seg_in, dig_en)
//   slave  : the scan multiplexer itself (drives seg_out, an_out, ...)
// Signals
//   seg_in      7*N_DIG  active-low patterns ABC_DEFG, digit k at [7k+6:7k]
//   dig_en      N_DIG    per-digit enable, 1 = digit lit
//   seg_out     7        active-low cathode bus ABC_DEFG
//   an_out      N_DIG    active-low anode strobes, at most one low
//   digit_idx   clog2    digit currently presented
//   frame_pulse 1        one-cycle high when a new snapshot is taken
// ---------------------------------------------------------------------------
interface seg7_scan_mux_if #(
  parameter int N_DIG = 4
);
  localparam int IW = $clog2(N_DIG);

  logic [7*N_DIG-1:0] seg_in;
  logic [N_DIG-1:0]   dig_en;
  logic [6:0]         seg_out;
  logic [N_DIG-1:0]   an_out;
  logic [IW-1:0]      digit_idx;
  logic               frame_pulse;

  modport master (
    output seg_in, dig_en,
    input  seg_out, an_out, digit_idx, frame_pulse
  );

  modport slave (
    input  seg_in, dig_en,
    output seg_out, an_out, digit_idx, frame_pulse
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexes N_DIG active-low 7-segment patterns onto one shared
//   cathode bus with active-low anode strobes. All patterns are snapshotted
//   once per scan frame so a frame never mixes old and new data.
// Ports
//   clk    in  system clock, posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of seg7_scan_mux_if (seg_in, dig_en in;
//          seg_out, an_out, digit_idx, frame_pulse out)
// Parameters
//   N_DIG        digits scanned (2..8)
//   REFRESH_DIV  clk cycles per digit slot (>=2)
//   BLANK_CYC    dead-time cycles at the start of each slot (1..REFRESH_DIV-1)
// Configuration
//   SEG7_GHOST_BLANK_EN  when defined, the first BLANK_CYC cycles of every
//                        slot are driven blank to suppress ghosting.
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIG);

`ifdef SEG7_GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic               prime;
  logic [7*N_DIG-1:0] shadow;

  logic               tick;
  logic               last_slot;
  logic               boundary;
  logic               blank;
  logic [6:0]         seg_nxt;
  logic [N_DIG-1:0]   an_nxt;

  assign tick      = (cnt == CW'(REFRESH_DIV - 1));
  assign last_slot = (idx == IW'(N_DIG - 1));
  // A prime edge and a wrap tick never need two pulses: both collapse here.
  assign boundary  = (tick && last_slot) || prime;
  // Dead time at the head of each slot; constant-folds away when disabled.
  assign blank     = GHOST_EN && (cnt < CW'(BLANK_CYC));

  // Prescaler, slot index and per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      prime  <= 1'b1;
      // NOTE: the snapshot is reset on purpose; until the prime edge loads
      // real data it must read as all segments off, never as X garbage.
      shadow <= '1;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge cnt/idx, which is what makes shadow and idx flip together.
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= last_slot ? '0 : idx + 1'b1;
      end
      if (boundary) begin
        shadow <= bus.seg_in;
      end
      prime <= 1'b0;
    end
  end

  // Next output values; dig_en is looked at live, only seg_in is snapshotted.
  always_comb begin
    // NOTE: defaults first so no path leaves seg_nxt/an_nxt unassigned,
    // which would otherwise infer a latch.
    seg_nxt = 7'h7F;
    an_nxt  = '1;
    if (bus.dig_en[idx] && !blank) begin
      seg_nxt = shadow[7*int'(idx) +: 7];
      an_nxt  = ~(N_DIG'(1) << idx);
    end
  end

  // Registered output stage, one cycle behind cnt/idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_out     <= 7'h7F;
      bus.an_out      <= '1;
      bus.digit_idx   <= '0;
      bus.frame_pulse <= 1'b0;
    end else begin
      bus.seg_out     <= seg_nxt;
      bus.an_out      <= an_nxt;
      bus.digit_idx   <= idx;
      bus.frame_pulse <= boundary;
    end
  end

endmodule
